// File: rtl/buffer_producto_pkg.sv
// Shared definitions for the multiplier output buffer.
// FSM encoding and datapath widths agreed with multiplicador3.
package buffer_producto_pkg;

    localparam int OPERAND_W  = 32;
    localparam int DATA_W_DEF = 2 * OPERAND_W;

    localparam logic [0:0] ESPERA  = 1'b0;
    localparam logic [0:0] ENTREGA = 1'b1;

endpackage

// File: rtl/buffer_producto_fifo_sinc.sv
// Synchronous FIFO, first-word-fall-through from registered memory.
// Head word reads as zero while empty.
module fifo_sinc #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count tracks push minus pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffer_producto.sv
// Product buffer: 4-phase capture from the multiplier into a FIFO,
// valid/ready drain, back-pressure on full and a stall counter.
module buffer_producto
    import buffer_producto_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  producto,
    input  logic               Done_Flag,
    output logic               ack,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W:0]    count,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [0:0] state;
    logic       full;
    logic       empty;
    logic       push;
    logic       stall_ev;

    // Full is the registered count, so a same-edge pop never frees a slot.
    assign push     = (state == ESPERA) && Done_Flag && !full;
    assign stall_ev = (state == ESPERA) && Done_Flag && full;
    assign out_valid = !empty;

    fifo_sinc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (out_ready),
        .wr_data (producto),
        .rd_data (out_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Handshake FSM: one capture per Done_Flag pulse, ack held until it drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ESPERA;
            ack   <= 1'b0;
        end else begin
            case (state)
                ESPERA: begin
                    if (push) begin
                        state <= ENTREGA;
                        ack   <= 1'b1;
                    end
                end
                ENTREGA: begin
                    if (!Done_Flag) begin
                        state <= ESPERA;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= ESPERA;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of refused requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_ev && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    // An unknown request while idle cannot be resolved safely.
    a_done_known: assert property (
        @(posedge clk) disable iff (!reset)
        (state == ESPERA) |-> !$isunknown(Done_Flag)
    );

endmodule

// File: tb/tb_buffer_producto.sv
// Directed bench for buffer_producto with a queue-based reference.
// Model checked every cycle plus hand-computed literal points.
module tb_buffer_producto;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] producto;
    logic          Done_Flag;
    logic          ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic [15:0]   stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    bit            m_ack = 1'b0;
    int            m_stall = 0;

    buffer_producto dut (
        .clk       (clk),
        .reset     (reset),
        .producto  (producto),
        .Done_Flag (Done_Flag),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted products and the handshake rules.
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_ack   = 1'b0;
            m_stall = 0;
        end else begin
            bit was_full;
            bit do_pop;
            was_full = (q.size() == DEPTH);
            do_pop   = (q.size() != 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (!m_ack) begin
                if (Done_Flag) begin
                    if (!was_full) begin
                        q.push_back(producto);
                        m_ack = 1'b1;
                    end else if (m_stall < 65535) begin
                        m_stall++;
                    end
                end
            end else if (!Done_Flag) begin
                m_ack = 1'b0;
            end
            #2;
            if (reset) begin
                chk("m_ack", ack, m_ack);
                chk("m_valid", out_valid, q.size() != 0);
                chk("m_data", out_data, (q.size() != 0) ? q[0] : '0);
                chk("m_count", count, q.size());
                chk("m_stall", stall_cnt, m_stall);
            end
        end
    end

    task automatic wait_ack(input bit lvl);
        int n;
        n = 0;
        while (ack !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_timeout", ack, lvl);
    endtask

    task automatic send(input logic [DW-1:0] w);
        @(negedge clk);
        producto  = w;
        Done_Flag = 1'b1;
        @(negedge clk);
        wait_ack(1'b1);
        Done_Flag = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);
    endtask

    logic [DW-1:0] drain_exp [4];

    initial begin
        reset     = 1'b0;
        producto  = '0;
        Done_Flag = 1'b0;
        out_ready = 1'b0;
        drain_exp[0] = 64'd60;
        drain_exp[1] = 64'd100;
        drain_exp[2] = 64'd7;
        drain_exp[3] = 64'd55;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b1;

        // 4*3*2 = 24 captured in one edge
        @(negedge clk);
        producto  = 64'd24;
        Done_Flag = 1'b1;
        @(negedge clk);
        chk("cap_ack", ack, 1);
        chk("cap_valid", out_valid, 1);
        chk("cap_data", out_data, 24);
        chk("cap_count", count, 1);
        Done_Flag = 1'b0;
        @(negedge clk);
        chk("rel_ack", ack, 0);

        send(64'd60);
        send(64'd100);
        send(64'd7);
        chk("full_count", count, 4);

        // fifth product refused while full
        producto  = 64'd55;
        Done_Flag = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_ack", ack, 0);
        chk("stall_count", count, 4);
        chk("stall_cnt3", stall_cnt, 3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_count", count, 3);
        chk("pop_stall", stall_cnt, 4);
        chk("pop_head", out_data, 60);
        chk("pop_ack", ack, 0);
        @(negedge clk);
        chk("late_ack", ack, 1);
        chk("late_count", count, 4);
        Done_Flag = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);

        // drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, drain_exp[i]);
            @(negedge clk);
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_count", count, 0);
        chk("drain_zero", out_data, 0);
        @(negedge clk);
        out_ready = 1'b0;

        // request held high: single capture
        producto  = 64'd77;
        Done_Flag = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("hold_ack", ack, 1);
            chk("hold_count", count, 1);
            @(negedge clk);
        end
        Done_Flag = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);

        // push and pop on the same edge at count 2
        send(64'd88);
        chk("two_count", count, 2);
        producto  = 64'd99;
        Done_Flag = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pp_count", count, 2);
        chk("pp_head", out_data, 88);
        chk("pp_ack", ack, 1);
        Done_Flag = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);

        // asynchronous reset during ENTREGA with three entries
        producto  = 64'd11;
        Done_Flag = 1'b1;
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_ack", ack, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_data", out_data, 0);
        Done_Flag = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        send(64'd42);
        chk("post_count", count, 1);
        chk("post_data", out_data, 42);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
